// File: rtl/cpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared types and constants for the CPU cycle sequencer.
//   phase_t      : sequencer phase reported on the mode output
//   T0..T6       : symbolic names for the default time states
//   DEF_*        : default widths and lengths used as parameter defaults
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

   // Phase encoding is visible on the mode port, so the values are fixed.
   typedef enum logic [1:0] {
      ADDRESS     = 2'd0,
      INSTRUCTION = 2'd1,
      INTERRUPT   = 2'd2
   } phase_t;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;
   localparam int T5 = 5;
   localparam int T6 = 6;

   localparam int DEF_INSTR_W = 6;
   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_MAX_T   = T6;
   localparam int DEF_INT_LEN = 7;

endpackage

// File: rtl/cycle_sequencer_edge_latch.sv
// -----------------------------------------------------------------------------
// edge_latch
// Rising-edge detector with a sticky pending bit. The edge is remembered until
// the consumer clears it, so events arriving while the consumer is busy or
// frozen are never lost. Used for NMI; intended for future RESET/BRK sources.
//   clk      in  : system clock, rising edge
//   rst      in  : asynchronous active-high reset
//   sig_in   in  : raw request line
//   clear    in  : consumer acknowledges the pending event
//   pending  out : registered sticky pending flag
// -----------------------------------------------------------------------------
module edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   input  logic clear,
   output logic pending
);

   logic prev_q, prev_d;
   logic pending_q, pending_d;

   // A new edge wins over a simultaneous clear so a back-to-back event
   // is not swallowed by the acknowledgement of the previous one.
   always_comb begin
      prev_d    = sig_in;
      pending_d = (pending_q & ~clear) | (sig_in & ~prev_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
// Time-state and phase sequencer for the CPU control path, sitting between the
// opcode decoder and the control-signal ROM. Tracks T0..MAX_T, the current
// phase (ADDRESS / INSTRUCTION / INTERRUPT), latches decoded opcode fields at
// instruction boundaries, and sequences NMI/IRQ entry.
//   clk, rst                  : clock and asynchronous active-high reset
//   enable                    : low freezes all sequencer state
//   no_addressing             : opcode skips the addressing phase
//   get_instruction           : instruction boundary
//   end_addressing            : last cycle of the addressing phase
//   irq, irq_mask             : level-sensitive maskable interrupt
//   nmi                       : rising-edge non-maskable interrupt
//   decoded_instruction/address : decoder outputs to latch
//   current_instruction/address : latched opcode fields
//   time_state, mode          : current T state and phase
//   int_is_nmi                : interrupt entry came from NMI
//   int_done                  : pulse on the last interrupt cycle
//   overrun                   : pulse when T wraps with no terminating event
// -----------------------------------------------------------------------------
module cycle_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int MAX_T   = DEF_MAX_T,
   parameter int INT_LEN = DEF_INT_LEN
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         no_addressing,
   input  logic                         get_instruction,
   input  logic                         end_addressing,
   input  logic                         irq,
   input  logic                         irq_mask,
   input  logic                         nmi,
   input  logic [INSTR_W-1:0]           decoded_instruction,
   input  logic [ADDR_W-1:0]            decoded_address,
   output logic [INSTR_W-1:0]           current_instruction,
   output logic [ADDR_W-1:0]            current_address,
   output logic [$clog2(MAX_T+1)-1:0]   time_state,
   output logic [1:0]                   mode,
   output logic                         int_is_nmi,
   output logic                         int_done,
   output logic                         overrun
);

   localparam int TIME_W = $clog2(MAX_T + 1);
   localparam logic [TIME_W-1:0] T_LAST = TIME_W'(MAX_T);
   localparam logic [TIME_W-1:0] T_INT_LAST = TIME_W'(INT_LEN - 1);
   localparam logic [TIME_W-1:0] T_ZERO = TIME_W'(T0);

   phase_t              mode_q, mode_d;
   logic [TIME_W-1:0]   time_q, time_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                is_nmi_q, is_nmi_d;
   logic                nmi_pending;
   logic                nmi_clear;

   edge_latch u_nmi_latch (
      .clk     (clk),
      .rst     (rst),
      .sig_in  (nmi),
      .clear   (nmi_clear),
      .pending (nmi_pending)
   );

   // Next-state decode. An active interrupt sequence runs to completion and
   // ignores boundary inputs; otherwise boundary events are prioritised
   // NMI > IRQ > enter instruction phase > enter address phase > free-run.
   always_comb begin
      mode_d    = mode_q;
      time_d    = time_q;
      instr_d   = instr_q;
      addr_d    = addr_q;
      is_nmi_d  = is_nmi_q;
      nmi_clear = 1'b0;
      int_done  = 1'b0;
      overrun   = 1'b0;
      if (enable) begin
         if (mode_q == INTERRUPT) begin
            if (time_q == T_INT_LAST) begin
               int_done = 1'b1;
               mode_d   = ADDRESS;
               time_d   = T_ZERO;
            end else begin
               time_d = time_q + TIME_W'(1);
            end
         end else if (get_instruction && nmi_pending) begin
            mode_d    = INTERRUPT;
            time_d    = T_ZERO;
            is_nmi_d  = 1'b1;
            nmi_clear = 1'b1;
         end else if (get_instruction && irq && !irq_mask) begin
            mode_d   = INTERRUPT;
            time_d   = T_ZERO;
            is_nmi_d = 1'b0;
         end else if (end_addressing || (get_instruction && no_addressing)) begin
            mode_d = INSTRUCTION;
            time_d = T_ZERO;
            if (get_instruction) begin
               instr_d = decoded_instruction;
               addr_d  = decoded_address;
            end
         end else if (get_instruction) begin
            mode_d  = ADDRESS;
            time_d  = T_ZERO;
            instr_d = decoded_instruction;
            addr_d  = decoded_address;
         end else if (time_q == T_LAST) begin
            time_d  = T_ZERO;
            overrun = 1'b1;
         end else begin
            time_d = time_q + TIME_W'(1);
         end
      end
   end

   // Sequencer state registers; reset aborts any interrupt in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= ADDRESS;
         time_q   <= T_ZERO;
         instr_q  <= '0;
         addr_q   <= '0;
         is_nmi_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         time_q   <= time_d;
         instr_q  <= instr_d;
         addr_q   <= addr_d;
         is_nmi_q <= is_nmi_d;
      end
   end

   assign current_instruction = instr_q;
   assign current_address     = addr_q;
   assign time_state          = time_q;
   assign mode                = mode_q;
   assign int_is_nmi          = is_nmi_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cycle_sequencer
// Self-checking bench for cycle_sequencer: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a reference model.
// -----------------------------------------------------------------------------
module tb_cycle_sequencer;

   localparam int INSTR_W = 6;
   localparam int ADDR_W  = 4;
   localparam int MAX_T   = 6;
   localparam int INT_LEN = 7;
   localparam int TIME_W  = 3;

   localparam int PH_ADDR  = 0;
   localparam int PH_INSTR = 1;
   localparam int PH_INT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic no_addressing = 1'b0;
   logic get_instruction = 1'b0;
   logic end_addressing = 1'b0;
   logic irq = 1'b0;
   logic irq_mask = 1'b0;
   logic nmi = 1'b0;
   logic [INSTR_W-1:0] decoded_instruction = '0;
   logic [ADDR_W-1:0]  decoded_address = '0;
   logic [INSTR_W-1:0] current_instruction;
   logic [ADDR_W-1:0]  current_address;
   logic [TIME_W-1:0]  time_state;
   logic [1:0]         mode;
   logic               int_is_nmi;
   logic               int_done;
   logic               overrun;

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model state: phase, time, latched fields, interrupt source,
   // the remembered NMI request and last sampled NMI level.
   int m_phase, m_time, m_instr, m_addr, m_src_nmi, m_nmi_waiting, m_nmi_last;

   always #5 clk = ~clk;

   cycle_sequencer #(
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W),
      .MAX_T   (MAX_T),
      .INT_LEN (INT_LEN)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .enable              (enable),
      .no_addressing       (no_addressing),
      .get_instruction     (get_instruction),
      .end_addressing      (end_addressing),
      .irq                 (irq),
      .irq_mask            (irq_mask),
      .nmi                 (nmi),
      .decoded_instruction (decoded_instruction),
      .decoded_address     (decoded_address),
      .current_instruction (current_instruction),
      .current_address     (current_address),
      .time_state          (time_state),
      .mode                (mode),
      .int_is_nmi          (int_is_nmi),
      .int_done            (int_done),
      .overrun             (overrun)
   );

   task automatic check(input string name, input int actual, input int expected);
      checks_total++;
      if (actual == expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   task automatic modelReset();
      m_phase = PH_ADDR; m_time = 0; m_instr = 0; m_addr = 0;
      m_src_nmi = 0; m_nmi_waiting = 0; m_nmi_last = 0;
   endtask

   // One clock of the model, written from the rules: an interrupt burst of
   // INT_LEN cycles, boundary arbitration, otherwise a T counter modulo MAX_T+1.
   task automatic modelStep();
      bit new_edge, nmi_taken, boundary;
      new_edge  = nmi && (m_nmi_last == 0);
      nmi_taken = 0;
      boundary  = get_instruction;
      m_nmi_last = nmi;
      if (enable) begin
         if (m_phase == PH_INT) begin
            m_time = m_time + 1;
            if (m_time == INT_LEN) begin m_phase = PH_ADDR; m_time = 0; end
         end else if (boundary && m_nmi_waiting != 0) begin
            m_phase = PH_INT; m_time = 0; m_src_nmi = 1; nmi_taken = 1;
         end else if (boundary && irq && !irq_mask) begin
            m_phase = PH_INT; m_time = 0; m_src_nmi = 0;
         end else if (boundary || end_addressing) begin
            if (boundary) begin
               m_instr = decoded_instruction;
               m_addr  = decoded_address;
            end
            m_phase = (end_addressing || no_addressing) ? PH_INSTR : PH_ADDR;
            m_time  = 0;
         end else begin
            m_time = (m_time + 1) % (MAX_T + 1);
         end
      end
      if (nmi_taken) m_nmi_waiting = 0;
      if (new_edge) m_nmi_waiting = 1;
   endtask

   task automatic checkOutput();
      int exp_done, exp_over;
      exp_done = (enable && m_phase == PH_INT && m_time == INT_LEN - 1) ? 1 : 0;
      exp_over = (enable && m_phase != PH_INT && !get_instruction && !end_addressing
                  && m_time == MAX_T) ? 1 : 0;
      check("mode", int'(mode), m_phase);
      check("time_state", int'(time_state), m_time);
      check("current_instruction", int'(current_instruction), m_instr);
      check("current_address", int'(current_address), m_addr);
      if (m_phase == PH_INT) check("int_is_nmi", int'(int_is_nmi), m_src_nmi);
      check("int_done", int'(int_done), exp_done);
      check("overrun", int'(overrun), exp_over);
   endtask

   task automatic applyStimulus(input logic en, input logic gi, input logic na,
                                input logic ea, input logic ir, input logic im,
                                input logic nm, input int di, input int da);
      enable              = en;
      get_instruction     = gi;
      no_addressing       = na;
      end_addressing      = ea;
      irq                 = ir;
      irq_mask            = im;
      nmi                 = nm;
      decoded_instruction = INSTR_W'(di);
      decoded_address     = ADDR_W'(da);
   endtask

   task automatic idle(input logic en);
      applyStimulus(en, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      if (rst) modelReset();
      #1 checkOutput();
      @(posedge clk);
      if (!rst) modelStep();
      @(negedge clk);
   endtask

   initial begin
      modelReset();
      @(negedge clk);
      #1 checkOutput();
      check("lit_reset_time", int'(time_state), 0);
      @(negedge clk);
      rst = 1'b0;

      // Free run: T0..T6 then wrap with an overrun pulse.
      idle(1);
      repeat (6) tick();
      #1 check("lit_time_T6", int'(time_state), 6);
      check("lit_overrun_at_T6", int'(overrun), 1);
      tick();
      #1 check("lit_time_wrap", int'(time_state), 0);
      check("lit_mode_addr", int'(mode), PH_ADDR);
      tick();

      // Boundary with no addressing: latch 2A/5, enter INSTRUCTION.
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 'h2A, 'h5);
      tick();
      idle(1);
      #1 check("lit_mode_instr", int'(mode), PH_INSTR);
      check("lit_instr_2A", int'(current_instruction), 'h2A);
      check("lit_addr_5", int'(current_address), 'h5);

      // Address phase, end_addressing at T3, then a normal boundary.
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 'h11, 'h3);
      tick();
      idle(1);
      repeat (3) tick();
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 'h22, 'h9);
      tick();
      idle(1);
      #1 check("lit_endaddr_mode", int'(mode), PH_INSTR);
      check("lit_endaddr_keep", int'(current_instruction), 'h11);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 'h3F, 'hA);
      tick();
      idle(1);
      #1 check("lit_reload_instr", int'(current_instruction), 'h3F);

      // IRQ entry, full interrupt burst, then masked IRQ is ignored.
      applyStimulus(1, 1, 0, 0, 1, 0, 0, 'h00, 'h0);
      tick();
      idle(1);
      #1 check("lit_irq_mode", int'(mode), PH_INT);
      check("lit_irq_src", int'(int_is_nmi), 0);
      check("lit_irq_latch_hold", int'(current_instruction), 'h3F);
      repeat (6) tick();
      #1 check("lit_int_done", int'(int_done), 1);
      tick();
      applyStimulus(1, 1, 1, 0, 1, 1, 0, 'h15, 'h2);
      tick();
      idle(1);
      #1 check("lit_masked_irq", int'(current_instruction), 'h15);

      // NMI edge while frozen, taken at next boundary ahead of IRQ.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      idle(0);
      repeat (2) tick();
      applyStimulus(1, 1, 0, 0, 1, 0, 0, 'h01, 'h1);
      tick();
      idle(1);
      #1 check("lit_nmi_mode", int'(mode), PH_INT);
      check("lit_nmi_src", int'(int_is_nmi), 1);
      repeat (INT_LEN) tick();

      // Freeze at INSTRUCTION T2, boundary inputs must be ignored.
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 'h07, 'h4);
      tick();
      idle(1);
      repeat (2) tick();
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 'h3C, 'hC);
      repeat (4) tick();
      #1 check("lit_frozen_time", int'(time_state), 2);
      check("lit_frozen_instr", int'(current_instruction), 'h07);

      // Reset in the middle of an interrupt at T3.
      applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 0);
      tick();
      idle(1);
      repeat (3) tick();
      #1 check("lit_int_T3", int'(time_state), 3);
      rst = 1'b1;
      #1 check("lit_rst_mode", int'(mode), PH_ADDR);
      check("lit_rst_instr", int'(current_instruction), 0);
      tick();
      rst = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                       ($urandom_range(0, 5) == 0),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Parametrised timing and opcode-latch sequencer for the CPU control path. It tracks the per-cycle time state (T0..MAX_T) and the current phase: ADDRESS, INSTRUCTION or the new INTERRUPT phase. It latches the decoded instruction and addressing-mode codes at each instruction boundary. It adds NMI/IRQ entry sequencing, a time-state overrun pulse, and configurable widths. It sits between the opcode decoder and the control-signal ROM.

Parameters:
INSTR_W, 6, width of the decoded instruction code
ADDR_W, 4, width of the decoded addressing-mode code
MAX_T, 6, highest legal time state; TIME_W = $clog2(MAX_T+1) is derived, not overridable
INT_LEN, 7, number of cycles in the interrupt entry sequence (2..MAX_T+1)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  global advance enable; low freezes the sequencer state
no_addressing  in  1  decoded opcode needs no addressing phase
get_instruction  in  1  last cycle of the current instruction (boundary)
end_addressing  in  1  last cycle of the addressing phase
irq  in  1  maskable interrupt request, level-sensitive
irq_mask  in  1  interrupt-disable flag from the status register
nmi  in  1  non-maskable request, rising-edge-sensitive
decoded_instruction  in  INSTR_W  decoder instruction code
decoded_address  in  ADDR_W  decoder addressing-mode code
current_instruction  out  INSTR_W  latched instruction code
current_address  out  ADDR_W  latched addressing-mode code
time_state  out  TIME_W  current T state
mode  out  2  phase_t: ADDRESS=0, INSTRUCTION=1, INTERRUPT=2
int_is_nmi  out  1  1 while in INTERRUPT mode when the entry was caused by NMI
int_done  out  1  one-cycle pulse on the last INTERRUPT cycle
overrun  out  1  one-cycle pulse when time_state wraps MAX_T->T0 without a terminating event

Behaviour:
- Reset (async, while rst=1): mode=ADDRESS, time_state=0, current_instruction=0, current_address=0, int_is_nmi=0, nmi_pending=0, nmi_prev=0, int_done=0, overrun=0.
- NMI detect: nmi_prev<=nmi every cycle, regardless of enable. nmi_pending is set when nmi & ~nmi_prev. It clears only when an NMI entry is taken, so edges are never lost while frozen.
- enable=0: mode, time_state, latches, int_is_nmi held; int_done=0 and overrun=0.
- With enable=1, next-state logic, first match wins:
  1. mode=INTERRUPT:
     - If time_state=INT_LEN-1: int_done=1, mode<=ADDRESS, time<=0.
     - Else time<=time+1.
     - get_instruction and end_addressing are ignored in this mode.
  2. get_instruction & nmi_pending: mode<=INTERRUPT, time<=0, int_is_nmi<=1, nmi_pending<=0. Opcode latches are not loaded.
  3. get_instruction & irq & ~irq_mask: mode<=INTERRUPT, time<=0, int_is_nmi<=0. Latches not loaded.
  4. end_addressing, or (get_instruction & no_addressing): mode<=INSTRUCTION, time<=0.
  5. get_instruction: mode<=ADDRESS, time<=0.
  6. Otherwise: mode held.
     - time<=time+1 while below MAX_T.
     - At MAX_T, time<=0 and overrun=1 for that cycle.
- Opcode latch: on enable & get_instruction with no interrupt taken (cases 4/5), load current_instruction<=decoded_instruction and current_address<=decoded_address. Otherwise both are held.
- int_is_nmi holds its value after the interrupt ends and is meaningful only while mode=INTERRUPT.
- NMI priority: an NMI edge and an IRQ at the same boundary -> NMI is taken; the IRQ stays visible by level.
- NMI arriving during INTERRUPT (including an IRQ entry) stays pending and is taken at the next get_instruction boundary.
- Latency: all outputs are registered and change one clk after the qualifying inputs. int_done and overrun are combinational decodes of registered state gated by enable.
- rst asserted mid-sequence aborts immediately to the reset values; no partial interrupt is resumed.

Decomposition:
- Package cpu_seq_pkg: phase_t enum (ADDRESS, INSTRUCTION, INTERRUPT), T0..T6 localparams, default widths.
- Sub-module edge_latch: rising-edge detector plus sticky pending bit with a clear input. It is used for NMI and is reusable for the future RESET/BRK sources.

Test Plan:
- Reset then enable=1, no events for 8 cycles -> time 0..6, 0; overrun pulses at the 6->0 step; mode stays ADDRESS.
- get_instruction=1, no_addressing=1, decoded_instruction=6'h2A, decoded_address=4'h5 -> next cycle mode=INSTRUCTION, time=0, latches 2A/5.
- end_addressing in ADDRESS at T3 -> mode=INSTRUCTION, T0. Then get_instruction with no_addressing=0 -> mode=ADDRESS, T0, latches reloaded.
- irq=1, irq_mask=0 at a boundary -> INTERRUPT, int_is_nmi=0, latches unchanged; int_done pulses at T6 (INT_LEN=7); then ADDRESS/T0. Repeat with irq_mask=1 -> normal fetch.
- nmi pulsed one cycle mid-instruction with enable=0 -> pending kept; at the next enabled boundary with irq also high -> INTERRUPT with int_is_nmi=1.
- enable=0 for 4 cycles at T2 in INSTRUCTION -> all outputs frozen, no pulses. rst asserted during INTERRUPT T3 -> immediate reset values.
